axis_multi_frame_buffer: RTL

Store-and-forward AXI-Stream packet buffer holding up to NUM_FRAMES complete frames of up to FRAME_DEPTH beats each, in a ring of frame slots. A frame becomes visible on the master side only after its tlast beat is written. The block adds selectable full-behaviour (backpressure or whole-frame drop), oversize-frame truncation with a flag, and occupancy/status outputs. It sits between packet producers and consumers in the pipeline.

---
 rtl/axis_fb_pkg.sv | 29 ++
 rtl/axis_fb_frame_mem.sv | 58 +++++
 rtl/axis_multi_frame_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fb_pkg.sv
// Shared definitions for the multi-frame AXI-Stream buffer.
//   - writer FSM state encoding
//   - default parameter values
//   - width helpers (index/slot/count widths derived with $clog2)
package axis_fb_pkg;

    typedef enum logic [1:0] {
        W_SOF     = 2'd0,
        W_BODY    = 2'd1,
        W_DISCARD = 2'd2,
        W_DROP    = 2'd3
    } wr_state_e;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_TID_WIDTH   = 8;
    localparam int DEF_FRAME_DEPTH = 16;
    localparam int DEF_NUM_FRAMES  = 4;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_fb_frame_mem.sv
// Frame slot storage: NUM_FRAMES x FRAME_DEPTH entries of {tlast, tid, data}
// plus one truncated flag per slot.
//   aclk                      clock
//   wr_en_i / wr_slot_i / wr_idx_i / wr_data_i / wr_tid_i / wr_last_i
//                             synchronous beat write port
//   flag_we_i / flag_i        synchronous write of the slot truncated flag
//   rd_slot_i / rd_idx_i      asynchronous read address
//   rd_data_o / rd_tid_o / rd_last_o / rd_flag_o   read data
// Contents are intentionally not reset.
module axis_fb_frame_mem
    import axis_fb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TID_WIDTH   = DEF_TID_WIDTH,
    parameter int FRAME_DEPTH = DEF_FRAME_DEPTH,
    parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
    parameter int IDX_W       = idx_width(FRAME_DEPTH),
    parameter int SLOT_W      = idx_width(NUM_FRAMES)
) (
    input  logic                  aclk,
    input  logic                  wr_en_i,
    input  logic [SLOT_W-1:0]     wr_slot_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [TID_WIDTH-1:0]  wr_tid_i,
    input  logic                  wr_last_i,
    input  logic                  flag_we_i,
    input  logic                  flag_i,
    input  logic [SLOT_W-1:0]     rd_slot_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [TID_WIDTH-1:0]  rd_tid_o,
    output logic                  rd_last_o,
    output logic                  rd_flag_o
);

    logic [DATA_WIDTH-1:0] data_q [NUM_FRAMES][FRAME_DEPTH];
    logic [TID_WIDTH-1:0]  tid_q  [NUM_FRAMES][FRAME_DEPTH];
    logic                  last_q [NUM_FRAMES][FRAME_DEPTH];
    logic                  flag_q [NUM_FRAMES];

    always_ff @(posedge aclk) begin
        if (wr_en_i) begin
            data_q[wr_slot_i][wr_idx_i] <= wr_data_i;
            tid_q[wr_slot_i][wr_idx_i]  <= wr_tid_i;
            last_q[wr_slot_i][wr_idx_i] <= wr_last_i;
        end
        if (flag_we_i) begin
            flag_q[wr_slot_i] <= flag_i;
        end
    end

    assign rd_data_o = data_q[rd_slot_i][rd_idx_i];
    assign rd_tid_o  = tid_q[rd_slot_i][rd_idx_i];
    assign rd_last_o = last_q[rd_slot_i][rd_idx_i];
    assign rd_flag_o = flag_q[rd_slot_i];

endmodule

// File: rtl/axis_multi_frame_buffer.sv
// Store-and-forward AXI-Stream buffer holding up to NUM_FRAMES whole frames
// of up to FRAME_DEPTH beats in a ring of slots. A frame is visible on the
// master side only once its tlast beat has been written.
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axis_*                 slave stream (tdata, tvalid, tready, tlast, tid)
//   m_axis_*                 master stream (tdata, tvalid, tready, tlast, tid,
//                            tuser = truncated flag on the tlast beat)
//   frame_count              committed frames currently held
//   drop_pulse / trunc_pulse high during the tlast handshake of a dropped /
//                            truncated frame
//
// Writer states:
//   state     | meaning
//   W_SOF     | waiting for the first beat of a frame
//   W_BODY    | storing beats into the current slot
//   W_DISCARD | slot full, discarding until tlast (which overwrites the last entry)
//   W_DROP    | frame arrived while full (drop mode), discarding until tlast
module axis_multi_frame_buffer
    import axis_fb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TID_WIDTH      = DEF_TID_WIDTH,
    parameter int FRAME_DEPTH    = DEF_FRAME_DEPTH,
    parameter int NUM_FRAMES     = DEF_NUM_FRAMES,
    parameter bit DROP_WHEN_FULL = 1'b0
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [TID_WIDTH-1:0]              s_axis_tid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [TID_WIDTH-1:0]              m_axis_tid,
    output logic                              m_axis_tuser,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_count,
    output logic                              drop_pulse,
    output logic                              trunc_pulse
);

    localparam int IDX_W  = idx_width(FRAME_DEPTH);
    localparam int SLOT_W = idx_width(NUM_FRAMES);
    localparam int CNT_W  = cnt_width(NUM_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_FRAMES);

    wr_state_e          state_q, state_d;
    logic [SLOT_W-1:0]  wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0]   w_idx_q, w_idx_d;
    logic [IDX_W-1:0]   r_idx_q, r_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full;
    logic               s_hs;
    logic               m_hs;
    logic               commit;
    logic               release_slot;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic               mem_last;
    logic               trunc_flag;
    logic               rd_last;
    logic               rd_flag;

    assign full = (count_q == FULL_CNT);

    // The in-progress frame never needs a free-slot check mid-frame: count_q
    // holds committed frames only, so a frame started below full keeps its slot.
    assign s_axis_tready = aresetn && (DROP_WHEN_FULL || !full || (state_q == W_DROP));
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d     = state_q;
        w_idx_d     = w_idx_q;
        wr_slot_d   = wr_slot_q;
        mem_we      = 1'b0;
        mem_idx     = w_idx_q;
        mem_last    = s_axis_tlast;
        commit      = 1'b0;
        trunc_flag  = 1'b0;
        drop_pulse  = 1'b0;
        trunc_pulse = 1'b0;

        unique case (state_q)
            W_SOF: begin
                if (s_hs) begin
                    if (DROP_WHEN_FULL && full) begin
                        // Drop is decided here only; a single-beat frame ends at once.
                        if (s_axis_tlast) begin
                            drop_pulse = 1'b1;
                        end else begin
                            state_d = W_DROP;
                        end
                    end else begin
                        mem_we  = 1'b1;
                        mem_idx = '0;
                        if (s_axis_tlast) begin
                            commit = 1'b1;
                        end else begin
                            state_d = W_BODY;
                            w_idx_d = IDX_W'(1);
                        end
                    end
                end
            end
            W_BODY: begin
                if (s_hs) begin
                    mem_we = 1'b1;
                    if (s_axis_tlast) begin
                        commit  = 1'b1;
                        state_d = W_SOF;
                        w_idx_d = '0;
                    end else if (w_idx_q == LAST_IDX) begin
                        state_d = W_DISCARD;
                    end else begin
                        w_idx_d = w_idx_q + IDX_W'(1);
                    end
                end
            end
            W_DISCARD: begin
                if (s_hs && s_axis_tlast) begin
                    mem_we      = 1'b1;
                    mem_idx     = LAST_IDX;
                    mem_last    = 1'b1;
                    trunc_flag  = 1'b1;
                    trunc_pulse = 1'b1;
                    commit      = 1'b1;
                    state_d     = W_SOF;
                    w_idx_d     = '0;
                end
            end
            W_DROP: begin
                if (s_hs && s_axis_tlast) begin
                    drop_pulse = 1'b1;
                    state_d    = W_SOF;
                end
            end
            default: state_d = W_SOF;
        endcase

        if (commit) begin
            wr_slot_d = wr_slot_q + SLOT_W'(1);
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign release_slot  = m_hs && rd_last;

    always_comb begin
        r_idx_d   = r_idx_q;
        rd_slot_d = rd_slot_q;
        if (m_hs) begin
            if (rd_last) begin
                r_idx_d   = '0;
                rd_slot_d = rd_slot_q + SLOT_W'(1);
            end else begin
                r_idx_d = r_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        unique case ({commit, release_slot})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= W_SOF;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            w_idx_q   <= '0;
            r_idx_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            w_idx_q   <= w_idx_d;
            r_idx_q   <= r_idx_d;
            count_q   <= count_d;
        end
    end

    axis_fb_frame_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TID_WIDTH   (TID_WIDTH),
        .FRAME_DEPTH (FRAME_DEPTH),
        .NUM_FRAMES  (NUM_FRAMES),
        .IDX_W       (IDX_W),
        .SLOT_W      (SLOT_W)
    ) u_mem (
        .aclk      (aclk),
        .wr_en_i   (mem_we),
        .wr_slot_i (wr_slot_q),
        .wr_idx_i  (mem_idx),
        .wr_data_i (s_axis_tdata),
        .wr_tid_i  (s_axis_tid),
        .wr_last_i (mem_last),
        .flag_we_i (commit),
        .flag_i    (trunc_flag),
        .rd_slot_i (rd_slot_q),
        .rd_idx_i  (r_idx_q),
        .rd_data_o (m_axis_tdata),
        .rd_tid_o  (m_axis_tid),
        .rd_last_o (rd_last),
        .rd_flag_o (rd_flag)
    );

    assign m_axis_tlast = rd_last;
    assign m_axis_tuser = rd_last && rd_flag;
    assign frame_count  = count_q;

endmodule
